// File: rtl/ahb64_sram_ctrl.sv
// AHB-Lite slave bridging the 64-bit RAM bus onto a single-port synchronous SRAM (1-cycle read latency).
// Reads and writes are zero-wait; a read address arriving during a write data phase costs one wait state.
module ahb64_sram_ctrl #(
  parameter int          WORDS     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  localparam int         AW        = $clog2(WORDS)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [31:0]   i_haddr,
  input  logic [2:0]    i_hburst,
  input  logic [2:0]    i_hsize,
  input  logic [3:0]    i_hprot,
  input  logic [1:0]    i_htrans,
  input  logic [63:0]   i_hwdata,
  input  logic          i_hwrite,
  output logic [63:0]   o_hrdata,
  output logic          o_hready,
  output logic          o_hresp,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [7:0]    o_mem_be,
  output logic [AW-1:0] o_mem_addr,
  output logic [63:0]   o_mem_wdata,
  input  logic [63:0]   i_mem_rdata
);
  typedef enum logic [2:0] {IDLE, RD_DATA, WR_DATA, RAW_STALL, ERR1, ERR2} state_t;
  localparam logic [32:0] SPAN = 33'(WORDS) * 33'd8;

  state_t        r_state, w_nxt;
  logic [AW-1:0] r_waddr, r_paddr;
  logic [7:0]    r_wbe, r_pbe;
  logic [31:0]   w_off;
  logic [AW-1:0] w_waddr;
  logic [3:0]    w_nb;
  logic [7:0]    w_mask, w_be;
  logic [15:0]   w_be16;
  logic [2:0]    w_amask;
  logic          w_legal, w_conf, w_rdy, w_samp;
  logic          w_unused;

  assign w_off   = i_haddr - BASE_ADDR;
  assign w_waddr = w_off[AW+2:3];
  assign w_nb    = 4'd1 << i_hsize[1:0];
  assign w_mask  = 8'((9'd1 << w_nb) - 9'd1);
  assign w_be16  = {8'd0, w_mask} << i_haddr[2:0];
  assign w_be    = w_be16[7:0];
  assign w_amask = 3'(w_nb - 4'd1);
  assign w_legal = !i_hsize[2] && ((i_haddr[2:0] & w_amask) == 3'd0) && ({1'b0, w_off} < SPAN);

  // The SRAM port is taken by the write, so a legal read presented now is parked in the pending register.
  assign w_conf  = (r_state == WR_DATA) && i_htrans[1] && !i_hwrite && w_legal;
  assign w_rdy   = (r_state != ERR1) && !w_conf;
  // In RAW_STALL the bus still shows the parked read; it must not be taken a second time.
  assign w_samp  = i_rst_n && w_rdy && i_htrans[1] && (r_state != RAW_STALL);

  assign w_unused = ^{i_hburst, i_hprot, w_be16[15:8]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_waddr <= '0;
      r_wbe   <= '0;
      r_paddr <= '0;
      r_pbe   <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_samp && w_legal && i_hwrite) begin
        r_waddr <= w_waddr;
        r_wbe   <= w_be;
      end
      if (w_conf) begin
        r_paddr <= w_waddr;
        r_pbe   <= w_be;
      end
    end
  end

  always_comb begin
    w_nxt       = IDLE;
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_be    = '0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    case (r_state)
      ERR1: w_nxt = ERR2;
      RAW_STALL: begin
        w_nxt      = RD_DATA;
        o_mem_en   = 1'b1;
        o_mem_be   = r_pbe;
        o_mem_addr = r_paddr;
      end
      default: begin
        if (w_conf)      w_nxt = RAW_STALL;
        else if (w_samp) w_nxt = !w_legal ? ERR1 : (i_hwrite ? WR_DATA : RD_DATA);
        if (r_state == WR_DATA) begin
          o_mem_en    = 1'b1;
          o_mem_we    = 1'b1;
          o_mem_be    = r_wbe;
          o_mem_addr  = r_waddr;
          o_mem_wdata = i_hwdata;
        end else if (w_samp && w_legal && !i_hwrite) begin
          o_mem_en   = 1'b1;
          o_mem_be   = w_be;
          o_mem_addr = w_waddr;
        end
      end
    endcase
  end

  assign o_hready = w_rdy;
  assign o_hresp  = (r_state == ERR1) || (r_state == ERR2);
  assign o_hrdata = (r_state == RD_DATA) ? i_mem_rdata : '0;
endmodule

// File: tb/tb_ahb64_sram_ctrl.sv
// Bench for ahb64_sram_ctrl: pipelined AHB driver, SRAM macro model, transfer-level reference model.
module tb_ahb64_sram_ctrl;
  localparam int          WORDS = 4096;
  localparam logic [31:0] BASE  = 32'h0;
  localparam int          AW    = $clog2(WORDS);

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic        wr;
    logic [63:0] data;
  } xfer_t;

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic [31:0]   i_haddr;
  logic [2:0]    i_hburst, i_hsize;
  logic [3:0]    i_hprot;
  logic [1:0]    i_htrans;
  logic [63:0]   i_hwdata;
  logic          i_hwrite;
  logic [63:0]   o_hrdata;
  logic          o_hready, o_hresp, o_mem_en, o_mem_we;
  logic [7:0]    o_mem_be;
  logic [AW-1:0] o_mem_addr;
  logic [63:0]   o_mem_wdata;
  logic [63:0]   mem_rdata;

  logic [63:0]   sram [0:WORDS-1];
  logic [7:0]    refm [0:WORDS*8-1];
  xfer_t         tq[$];
  logic [7:0]    be_log[$];
  logic [AW-1:0] wa_log[$];
  int            addr_cyc [0:255];
  int            done_cyc [0:255];
  int            checks = 0, errors = 0, en_cnt = 0, nwait = 0;
  logic [63:0]   last_rd;

  always #5 clk = ~clk;

  ahb64_sram_ctrl #(.WORDS(WORDS), .BASE_ADDR(BASE)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_haddr(i_haddr), .i_hburst(i_hburst), .i_hsize(i_hsize),
    .i_hprot(i_hprot), .i_htrans(i_htrans), .i_hwdata(i_hwdata), .i_hwrite(i_hwrite),
    .o_hrdata(o_hrdata), .o_hready(o_hready), .o_hresp(o_hresp), .o_mem_en(o_mem_en),
    .o_mem_we(o_mem_we), .o_mem_be(o_mem_be), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata)
  );

  function automatic logic [63:0] be_mask(input logic [7:0] be);
    logic [63:0] m = '0;
    for (int b = 0; b < 8; b++) if (be[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  // SRAM macro: registered read data, byte-masked write.
  always @(posedge clk) begin
    if (o_mem_en) begin
      if (o_mem_we) sram[o_mem_addr] <= (sram[o_mem_addr] & ~be_mask(o_mem_be)) | (o_mem_wdata & be_mask(o_mem_be));
      else          mem_rdata <= sram[o_mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic xfer_t mk(input logic [31:0] a, input logic [2:0] s, input logic [1:0] t,
                               input logic w, input logic [63:0] d);
    xfer_t x;
    x.addr = a; x.size = s; x.trans = t; x.wr = w; x.data = d;
    return x;
  endfunction

  function automatic bit legal(input xfer_t x);
    logic [31:0] off = x.addr - BASE;
    if (x.size > 3) return 0;
    if ((x.addr % (32'd1 << x.size)) != 0) return 0;
    return off < 32'(WORDS * 8);
  endfunction

  function automatic bit is_rd(input int i);
    return tq[i].trans[1] && legal(tq[i]) && !tq[i].wr;
  endfunction
  function automatic bit is_wr(input int i);
    return tq[i].trans[1] && legal(tq[i]) && tq[i].wr;
  endfunction
  function automatic bit exp_err(input int i);
    return tq[i].trans[1] && !legal(tq[i]);
  endfunction
  // Error: one wait; write whose successor is a legal read: one wait; anything else: none.
  function automatic int exp_waits(input int i);
    if (exp_err(i)) return 1;
    if (is_wr(i) && (i + 1 < tq.size()) && is_rd(i + 1)) return 1;
    return 0;
  endfunction

  function automatic logic [63:0] rd_word(input logic [31:0] a);
    int base = int'((a - BASE) & ~32'd7);
    logic [63:0] w;
    for (int b = 0; b < 8; b++) w[b*8 +: 8] = refm[base + b];
    return w;
  endfunction

  task automatic apply_wr(input xfer_t x);
    int off = int'(x.addr - BASE);
    for (int b = 0; b < (1 << x.size); b++) refm[off + b] = x.data[((off % 8) + b)*8 +: 8];
  endtask

  task automatic bus_idle();
    i_htrans = 2'd0; i_hwrite = 1'b0; i_haddr = '0; i_hsize = '0; i_hwdata = '0;
    i_hburst = '0; i_hprot = '0;
  endtask

  // Runs tq as a pipelined AHB master; entered and left at posedge+1.
  task automatic run();
    int  ai = 0, di = -1, waits = 0;
    bit  done = 0;
    en_cnt = 0; nwait = 0; be_log.delete(); wa_log.delete();
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (ai < tq.size()) begin
        i_haddr = tq[ai].addr; i_hsize = tq[ai].size; i_htrans = tq[ai].trans; i_hwrite = tq[ai].wr;
      end else begin
        i_haddr = '0; i_hsize = '0; i_htrans = 2'd0; i_hwrite = 1'b0;
      end
      i_hburst = 3'($urandom); i_hprot = 4'($urandom);
      i_hwdata = (di >= 0 && tq[di].wr) ? tq[di].data : 64'h0;
      @(negedge clk);
      if (o_mem_en) en_cnt++;
      if (o_mem_en && o_mem_we) begin be_log.push_back(o_mem_be); wa_log.push_back(o_mem_addr); end
      if (di < 0) chk("first_ready", 64'(o_hready), 1);
      else if (!o_hready) begin
        waits++; nwait++;
        chk("wait_resp", 64'(o_hresp), 64'(exp_err(di)));
      end else begin
        chk("waits", 64'(waits), 64'(exp_waits(di)));
        chk("resp", 64'(o_hresp), 64'(exp_err(di)));
        if (is_rd(di)) begin
          chk("rdata", o_hrdata, rd_word(tq[di].addr));
          last_rd = o_hrdata;
        end else chk("rdata_zero", o_hrdata, 64'h0);
        if (is_wr(di)) apply_wr(tq[di]);
        done_cyc[di] = cyc; waits = 0;
      end
      if (o_hready) begin
        if (ai < tq.size()) begin addr_cyc[ai] = cyc; di = ai; ai++; end
        else begin di = -1; done = 1; end
      end
      @(posedge clk); #1;
    end
    chk("run_timeout", 64'(done), 1);
    bus_idle();
  endtask

  initial begin
    xfer_t wx;
    logic [63:0] d;
    int r;
    bus_idle();
    i_rst_n = 1'b0;
    for (int i = 0; i < WORDS * 8; i++) refm[i] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hready", 64'(o_hready), 1);
    chk("rst_hresp", 64'(o_hresp), 0);
    chk("rst_en", 64'(o_mem_en), 0);
    chk("rst_we", 64'(o_mem_we), 0);
    chk("rst_be", 64'(o_mem_be), 0);
    chk("rst_addr", 64'(o_mem_addr), 0);
    chk("rst_wdata", o_mem_wdata, 0);
    chk("rst_hrdata", o_hrdata, 0);
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero the words the bench touches; back-to-back writes must not stall.
    tq.delete();
    for (int i = 0; i < 9; i++) tq.push_back(mk(32'(i * 8), 3'd3, 2'd2, 1'b1, 64'h0));
    run();
    chk("ww_nostall", 64'(nwait), 0);

    tq.delete();
    tq.push_back(mk(32'h10, 3'd3, 2'd2, 1'b1, 64'h1122334455667788));
    tq.push_back(mk(32'h0, 3'd0, 2'd0, 1'b0, 64'h0));
    tq.push_back(mk(32'h10, 3'd3, 2'd2, 1'b0, 64'h0));
    run();
    chk("w64_count", 64'(be_log.size()), 1);
    chk("w64_be", 64'(be_log[0]), 64'hFF);
    chk("w64_addr", 64'(wa_log[0]), 2);
    chk("w64_nostall", 64'(nwait), 0);
    chk("w64_rd", last_rd, 64'h1122334455667788);

    tq.delete();
    tq.push_back(mk(32'h13, 3'd0, 2'd2, 1'b1, 64'h00000000AB000000));
    tq.push_back(mk(32'h16, 3'd1, 2'd2, 1'b1, 64'hCDEF000000000000));
    tq.push_back(mk(32'h0, 3'd0, 2'd0, 1'b0, 64'h0));
    tq.push_back(mk(32'h10, 3'd3, 2'd2, 1'b0, 64'h0));
    run();
    chk("byte_be", 64'(be_log[0]), 64'h08);
    chk("half_be", 64'(be_log[1]), 64'hC0);
    chk("merge_rd", last_rd, 64'hCDEF3344AB667788);

    tq.delete();
    tq.push_back(mk(32'h20, 3'd3, 2'd2, 1'b1, 64'hDEADBEEF0BADF00D));
    tq.push_back(mk(32'h20, 3'd3, 2'd2, 1'b0, 64'h0));
    run();
    chk("raw_stalls", 64'(nwait), 1);
    chk("raw_latency", 64'(done_cyc[1] - addr_cyc[0]), 3);
    chk("raw_rd", last_rd, 64'hDEADBEEF0BADF00D);

    tq.delete();
    tq.push_back(mk(32'h22, 3'd2, 2'd2, 1'b0, 64'h0));
    tq.push_back(mk(32'h0, 3'd0, 2'd0, 1'b0, 64'h0));
    tq.push_back(mk(BASE + 32'(WORDS * 8), 3'd3, 2'd2, 1'b0, 64'h0));
    tq.push_back(mk(32'h0, 3'd0, 2'd0, 1'b0, 64'h0));
    run();
    chk("err_no_en", 64'(en_cnt), 0);
    chk("err_waits", 64'(nwait), 2);

    tq.delete();
    tq.push_back(mk(32'h00, 3'd3, 2'd2, 1'b0, 64'h0));
    tq.push_back(mk(32'h08, 3'd3, 2'd3, 1'b0, 64'h0));
    tq.push_back(mk(32'h10, 3'd3, 2'd1, 1'b0, 64'h0));
    tq.push_back(mk(32'h10, 3'd3, 2'd3, 1'b0, 64'h0));
    tq.push_back(mk(32'h18, 3'd3, 2'd3, 1'b0, 64'h0));
    run();
    chk("burst_en", 64'(en_cnt), 4);
    chk("burst_nostall", 64'(nwait), 0);

    // Reset while the parked read sits in the stall cycle.
    d = 64'h0123456789ABCDEF;
    wx = mk(32'h40, 3'd3, 2'd2, 1'b1, d);
    i_haddr = 32'h40; i_hsize = 3'd3; i_htrans = 2'd2; i_hwrite = 1'b1;
    @(posedge clk); #1;
    i_hwrite = 1'b0; i_hwdata = d;
    @(negedge clk);
    chk("rst_conf_rdy", 64'(o_hready), 0);
    @(posedge clk); #1;
    chk("stall_issue", 64'(o_mem_en), 1);
    i_rst_n = 1'b0; #1;
    chk("arst_hready", 64'(o_hready), 1);
    chk("arst_hresp", 64'(o_hresp), 0);
    chk("arst_en", 64'(o_mem_en), 0);
    chk("arst_addr", 64'(o_mem_addr), 0);
    chk("arst_hrdata", o_hrdata, 0);
    bus_idle();
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_pending_rd", 64'(o_mem_en), 0);
    end
    @(posedge clk); #1;
    apply_wr(wx);
    tq.delete();
    tq.push_back(mk(32'h40, 3'd3, 2'd2, 1'b0, 64'h0));
    run();
    chk("post_rst_rd", last_rd, d);

    for (int round = 0; round < 4; round++) begin
      tq.delete();
      for (int k = 0; k < 40; k++) begin
        xfer_t x;
        r = $urandom_range(0, 7);
        x.trans = (r < 5) ? 2'd2 : (r == 5) ? 2'd3 : (r == 6) ? 2'd0 : 2'd1;
        x.size  = ($urandom_range(0, 15) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
        x.addr  = 32'($urandom_range(0, 71));
        if ($urandom_range(0, 3) != 0) x.addr = x.addr & ~((32'd1 << x.size) - 32'd1);
        if ($urandom_range(0, 15) == 0) x.addr = x.addr + 32'(WORDS * 8);
        x.wr    = 1'($urandom_range(0, 1));
        x.data  = {$urandom, $urandom};
        tq.push_back(x);
      end
      run();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
